// File: rtl/handshake_pkg.sv
// handshake_pkg: shared encodings and defaults for the 4-phase req/ack CDC handshake (rx and tx sides)
package handshake_pkg;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam logic [1:0] RX_WAIT_REQ      = 2'd0;
  localparam logic [1:0] RX_SEND_VALID    = 2'd1;
  localparam logic [1:0] RX_WAIT_REQ_DOWN = 2'd2;
  localparam logic [1:0] TX_IDLE          = 2'd0;
  localparam logic [1:0] TX_WAIT_ACK      = 2'd1;
  localparam logic [1:0] TX_WAIT_ACK_DOWN = 2'd2;
  typedef enum logic [1:0] {
    RxWaitReq     = RX_WAIT_REQ,
    RxSendValid   = RX_SEND_VALID,
    RxWaitReqDown = RX_WAIT_REQ_DOWN
  } rx_state_e;
  typedef enum logic [1:0] {
    TxIdle        = TX_IDLE,
    TxWaitAck     = TX_WAIT_ACK,
    TxWaitAckDown = TX_WAIT_ACK_DOWN
  } tx_state_e;
endpackage

// File: rtl/handshake_rx_if.sv
// handshake_rx_if: sender req/data/ack plus downstream valid/ready/rdata; slave = receive endpoint, master = sender + consumer
interface handshake_rx_if #(parameter int DATA_WIDTH = handshake_pkg::DEF_DATA_WIDTH) ();
  logic                  i_req;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_ack;
  logic                  o_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_rdata;
  modport slave (input i_req, i_data, o_ready, output o_ack, o_valid, o_rdata);
  modport master (output i_req, i_data, o_ready, input o_ack, o_valid, o_rdata);
endinterface

// File: rtl/hs_sync.sv
// hs_sync: STAGES-flop single-bit synchroniser, sync active-low reset (ports clk, rstn, d async in, q synced out)
module hs_sync
  import handshake_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk) ff <= !rstn ? '0 : {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/handshake_rx.sv
// handshake_rx: receive endpoint of 4-phase req/ack CDC; ports o_clk, o_rstn (sync active-low), bus (req/data/ack + valid/ready/rdata), o_err, o_xfer_cnt
module handshake_rx
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 o_clk,
  input  logic                 o_rstn,
  handshake_rx_if.slave        bus,
  output logic                 o_err,
  output logic [CNT_WIDTH-1:0] o_xfer_cnt
);
  rx_state_e             state, state_n;
  logic                  req_s, ack_q, ack_n, err_n, primed;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic [CNT_WIDTH-1:0]  cnt_n;
  logic [SYNC_STAGES-1:0] fill;
  hs_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(o_clk), .rstn(o_rstn), .d(bus.i_req), .q(req_s));
  // The synchroniser restarts from zero on reset, so its first outputs are not a real
  // view of i_req; hold off leaving RxWaitReqDown until it has refilled, otherwise a
  // request held high across reset would look like a fresh rising edge.
  always_ff @(posedge o_clk) fill <= !o_rstn ? '0 : {fill[SYNC_STAGES-2:0], 1'b1};
  assign primed = fill[SYNC_STAGES-1];
  always_ff @(posedge o_clk) begin
    if (!o_rstn) begin
      state      <= RxWaitReqDown;
      ack_q      <= 1'b0;
      o_err      <= 1'b0;
      data_q     <= '0;
      o_xfer_cnt <= '0;
    end else begin
      state      <= state_n;
      ack_q      <= ack_n;
      o_err      <= err_n;
      data_q     <= data_n;
      o_xfer_cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    ack_n   = ack_q;
    data_n  = data_q;
    cnt_n   = o_xfer_cnt;
    err_n   = o_err | (state == RxSendValid && !req_s);
    case (state)
      RxWaitReqDown: begin
        ack_n   = (!req_s && primed) ? 1'b0 : ack_q;
        state_n = (!req_s && primed) ? RxWaitReq : state;
      end
      RxWaitReq: begin
        data_n  = req_s ? bus.i_data : data_q;
        state_n = req_s ? RxSendValid : state;
      end
      RxSendValid: begin
        ack_n   = bus.o_ready ? 1'b1 : ack_q;
        cnt_n   = bus.o_ready ? o_xfer_cnt + 1'b1 : o_xfer_cnt;
        state_n = bus.o_ready ? RxWaitReqDown : state;
      end
      default: state_n = RxWaitReqDown;
    endcase
  end
  assign bus.o_ack   = ack_q;
  assign bus.o_valid = (state == RxSendValid);
  assign bus.o_rdata = data_q;
endmodule

// File: tb/tb_handshake_rx.sv
// tb_handshake_rx: table-driven plus directed-sequence bench for handshake_rx
module tb_handshake_rx;
  logic       o_clk = 1'b0;
  logic       o_rstn;
  logic       o_err;
  logic [1:0] o_xfer_cnt;
  int checks = 0;
  int errors = 0;
  handshake_rx_if #(.DATA_WIDTH(16)) bus ();
  handshake_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2), .CNT_WIDTH(2)) dut (
    .o_clk(o_clk), .o_rstn(o_rstn), .bus(bus), .o_err(o_err), .o_xfer_cnt(o_xfer_cnt)
  );
  always #5 o_clk = ~o_clk;
  typedef struct {
    logic rstn; logic req; logic [15:0] data; logic ready;
    logic valid; logic ack; logic err; logic [15:0] rdata; logic [1:0] cnt;
  } vec_t;
  vec_t tbl[22];
  function automatic vec_t row(logic rstn, logic req, logic [15:0] data, logic ready,
                               logic valid, logic ack, logic err, logic [15:0] rdata, logic [1:0] cnt);
    row = '{rstn, req, data, ready, valid, ack, err, rdata, cnt};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge o_clk);
      #1;
    end
  endtask
  task automatic drive(input logic rstn, input logic req, input logic [15:0] data, input logic ready);
    o_rstn = rstn;
    bus.i_req = req;
    bus.i_data = data;
    bus.o_ready = ready;
  endtask
  logic [15:0] w;
  initial begin
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    // single transfer, then a withdrawn request accepted in the same cycle req_s falls
    tbl[0]  = row(0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    tbl[1]  = row(1, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    tbl[2]  = row(1, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    tbl[3]  = row(1, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    tbl[4]  = row(1, 1, 16'hA5C3, 1, 0, 0, 0, 16'h0000, 0);
    tbl[5]  = row(1, 1, 16'hA5C3, 1, 0, 0, 0, 16'h0000, 0);
    tbl[6]  = row(1, 1, 16'hA5C3, 1, 1, 0, 0, 16'hA5C3, 0);
    tbl[7]  = row(1, 1, 16'hA5C3, 1, 0, 1, 0, 16'hA5C3, 1);
    tbl[8]  = row(1, 0, 16'hA5C3, 1, 0, 1, 0, 16'hA5C3, 1);
    tbl[9]  = row(1, 0, 16'hA5C3, 1, 0, 1, 0, 16'hA5C3, 1);
    tbl[10] = row(1, 0, 16'hA5C3, 1, 0, 0, 0, 16'hA5C3, 1);
    tbl[11] = row(1, 1, 16'h0F0F, 0, 0, 0, 0, 16'hA5C3, 1);
    tbl[12] = row(1, 1, 16'h0F0F, 0, 0, 0, 0, 16'hA5C3, 1);
    tbl[13] = row(1, 1, 16'h0F0F, 0, 1, 0, 0, 16'h0F0F, 1);
    tbl[14] = row(1, 0, 16'h0F0F, 0, 1, 0, 0, 16'h0F0F, 1);
    tbl[15] = row(1, 0, 16'h0F0F, 0, 1, 0, 0, 16'h0F0F, 1);
    tbl[16] = row(1, 0, 16'h0F0F, 1, 0, 1, 1, 16'h0F0F, 2);
    tbl[17] = row(1, 0, 16'h0F0F, 1, 0, 0, 1, 16'h0F0F, 2);
    tbl[18] = row(0, 0, 16'h0F0F, 1, 0, 0, 0, 16'h0000, 0);
    tbl[19] = row(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0);
    tbl[20] = row(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0);
    tbl[21] = row(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0);
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rstn, tbl[i].req, tbl[i].data, tbl[i].ready);
      step();
      chk($sformatf("row%0d valid", i), 32'(bus.o_valid), 32'(tbl[i].valid));
      chk($sformatf("row%0d ack", i), 32'(bus.o_ack), 32'(tbl[i].ack));
      chk($sformatf("row%0d err", i), 32'(o_err), 32'(tbl[i].err));
      chk($sformatf("row%0d rdata", i), 32'(bus.o_rdata), 32'(tbl[i].rdata));
      chk($sformatf("row%0d cnt", i), 32'(o_xfer_cnt), 32'(tbl[i].cnt));
    end
    // backpressure: valid/rdata held for 10 stalled cycles, ack on the accepting edge
    drive(1, 1, 16'h1234, 0);
    step(2);
    chk("bp valid_early", 32'(bus.o_valid), 32'd0);
    step();
    chk("bp valid", 32'(bus.o_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp hold valid", 32'(bus.o_valid), 32'd1);
      chk("bp hold rdata", 32'(bus.o_rdata), 32'h1234);
      chk("bp hold ack", 32'(bus.o_ack), 32'd0);
    end
    bus.o_ready = 1'b1;
    step();
    chk("bp ack", 32'(bus.o_ack), 32'd1);
    chk("bp valid_drop", 32'(bus.o_valid), 32'd0);
    chk("bp cnt", 32'(o_xfer_cnt), 32'd1);
    bus.i_req = 1'b0;
    step(2);
    chk("bp ack_held", 32'(bus.o_ack), 32'd1);
    step();
    chk("bp ack_low", 32'(bus.o_ack), 32'd0);
    // reset mid-RxSendValid with the request held high
    drive(1, 1, 16'hBEEF, 0);
    step(3);
    chk("rst valid_before", 32'(bus.o_valid), 32'd1);
    o_rstn = 1'b0;
    step();
    chk("rst valid", 32'(bus.o_valid), 32'd0);
    chk("rst ack", 32'(bus.o_ack), 32'd0);
    chk("rst cnt", 32'(o_xfer_cnt), 32'd0);
    chk("rst rdata", 32'(bus.o_rdata), 32'd0);
    o_rstn = 1'b1;
    bus.o_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst held_req valid", 32'(bus.o_valid), 32'd0);
      chk("rst held_req cnt", 32'(o_xfer_cnt), 32'd0);
    end
    bus.i_req = 1'b0;
    step(3);
    drive(1, 1, 16'hCAFE, 1);
    step(3);
    chk("rst fresh valid", 32'(bus.o_valid), 32'd1);
    chk("rst fresh rdata", 32'(bus.o_rdata), 32'hCAFE);
    step();
    chk("rst fresh ack", 32'(bus.o_ack), 32'd1);
    chk("rst fresh cnt", 32'(o_xfer_cnt), 32'd1);
    bus.i_req = 1'b0;
    step(3);
    chk("rst fresh ack_low", 32'(bus.o_ack), 32'd0);
    // withdrawn request while stalled
    drive(1, 1, 16'h5A5A, 0);
    step(3);
    chk("wd valid", 32'(bus.o_valid), 32'd1);
    bus.i_req = 1'b0;
    step(2);
    chk("wd err_early", 32'(o_err), 32'd0);
    chk("wd valid_kept", 32'(bus.o_valid), 32'd1);
    step();
    chk("wd err", 32'(o_err), 32'd1);
    chk("wd valid_still", 32'(bus.o_valid), 32'd1);
    bus.o_ready = 1'b1;
    step();
    chk("wd ack_pulse", 32'(bus.o_ack), 32'd1);
    chk("wd rdata", 32'(bus.o_rdata), 32'h5A5A);
    chk("wd cnt", 32'(o_xfer_cnt), 32'd2);
    step();
    chk("wd ack_end", 32'(bus.o_ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wd err_sticky", 32'(o_err), 32'd1);
    end
    // counter wrap across five full handshakes
    o_rstn = 1'b0;
    step();
    chk("wrap err_cleared", 32'(o_err), 32'd0);
    o_rstn = 1'b1;
    step(3);
    for (int k = 0; k < 5; k++) begin
      w = 16'($urandom_range(0, 16'hFFFF));
      drive(1, 1, w, 1);
      step(3);
      chk($sformatf("wrap%0d valid", k), 32'(bus.o_valid), 32'd1);
      chk($sformatf("wrap%0d rdata", k), 32'(bus.o_rdata), 32'(w));
      step();
      chk($sformatf("wrap%0d ack", k), 32'(bus.o_ack), 32'd1);
      chk($sformatf("wrap%0d cnt", k), 32'(o_xfer_cnt), 32'((k + 1) % 4));
      bus.i_req = 1'b0;
      step(3);
      chk($sformatf("wrap%0d ack_low", k), 32'(bus.o_ack), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
